multicycle_control_fsm: RTL and testbench

- Multi-cycle control unit for the 16-bit CPU; sits at the other end of the datapath's control interface.
- Consumes the 4-bit opcode the datapath exports and sequences the datapath control strobes over FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Handshakes with a variable-latency data memory via MemReady.
- Provides a retired-instruction counter, halt and fault status.

---
 rtl/multicycle_control_fsm_if.sv | 46 ++++
 rtl/multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm_if
// Brief   : Control bundle between the multi-cycle control FSM and the
//           16-bit datapath. It carries the opcode and memory handshake in,
//           and the control strobes and status out.
// Revision: 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if #(
  parameter int COUNT_W = 16
);
  logic [3:0]         opcode;
  logic               MemReady;
  logic               PCWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               Branch;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               MemToReg;
  logic               ALUSrc;
  logic               Shift;
  logic [1:0]         ALUOp;
  logic               Halted;
  logic               IllegalOp;
  logic               BusError;
  logic [COUNT_W-1:0] RetiredCount;

  // Control unit side: it consumes the opcode and handshake and drives the strobes.
  modport master (
    input  opcode, MemReady,
    output PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
           MemToReg, ALUSrc, Shift, ALUOp, Halted, IllegalOp, BusError,
           RetiredCount
  );

  // Datapath / memory side.
  modport slave (
    output opcode, MemReady,
    input  PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
           MemToReg, ALUSrc, Shift, ALUOp, Halted, IllegalOp, BusError,
           RetiredCount
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : Multi-cycle control unit for the 16-bit CPU. It sequences
//           FETCH/DECODE/EXECUTE/MEM/WRITEBACK, waits on a variable-latency
//           data memory, and reports retired count, halt and fault status.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic                Clock,
  input  wire logic                Reset,
  multicycle_control_fsm_if.master bus
);

  localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_SHFT = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_ANDI = 4'h3;
  localparam logic [3:0] OP_ORI  = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic [3:0]          op_q, op_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_nx;
  logic                illegal_q, illegal_nx;
  logic                bus_err_q, bus_err_nx;
  logic [COUNT_W-1:0]  retired_q;

  // Decoded ALU-side controls of the latched instruction
  logic       dec_reg_dst, dec_shift, dec_alu_src;
  logic [1:0] dec_alu_op;
  logic       is_lw, is_sw, is_beq;

  // Raw Moore controls before the reset gate
  logic       pc_write, ir_write, reg_dst, branch, mem_read, mem_write;
  logic       reg_write, mem_to_reg, alu_src, shift;
  logic [1:0] alu_op;

  // Decode the latched opcode into ALU/datapath steering
  always_comb begin
    dec_reg_dst = 1'b0;
    dec_shift   = 1'b0;
    dec_alu_src = 1'b0;
    dec_alu_op  = 2'b00;
    case (op_q)
      OP_R:    begin dec_reg_dst = 1'b1; dec_alu_op = 2'b10; end
      OP_SHFT: begin dec_reg_dst = 1'b1; dec_shift = 1'b1; dec_alu_op = 2'b10; end
      OP_ADDI,
      OP_ANDI,
      OP_ORI:  begin dec_alu_src = 1'b1; dec_alu_op = 2'b11; end
      OP_LW,
      OP_SW:   begin dec_alu_src = 1'b1; dec_alu_op = 2'b00; end
      OP_BEQ:  dec_alu_op = 2'b01;
      default: ;
    endcase
  end

  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);

  // Next-state, next-register values and Moore control outputs
  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    wait_nx    = wait_cnt;
    illegal_nx = illegal_q;
    bus_err_nx = bus_err_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    shift      = 1'b0;
    alu_op     = 2'b00;

    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        state_nx = S_DECODE;
      end

      S_DECODE: begin
        op_nx = bus.opcode;
        if (bus.opcode == OP_HALT) begin
          state_nx = S_HALT;
        end else if (bus.opcode[3]) begin
          illegal_nx = 1'b1;
          state_nx   = S_HALT;
        end else begin
          state_nx = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        reg_dst = dec_reg_dst;
        shift   = dec_shift;
        alu_src = dec_alu_src;
        alu_op  = dec_alu_op;
        if (is_beq) begin
          branch   = 1'b1;
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end else if (is_lw || is_sw) begin
          wait_nx  = '0;
          state_nx = S_MEM;
        end else begin
          state_nx = S_WRITEBACK;
        end
      end

      S_MEM: begin
        reg_dst   = dec_reg_dst;
        shift     = dec_shift;
        alu_src   = dec_alu_src;
        alu_op    = dec_alu_op;
        mem_read  = is_lw;
        mem_write = is_sw;
        // A completion in the timeout cycle wins over the fault.
        if (bus.MemReady) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          bus_err_nx = 1'b1;
          state_nx   = S_HALT;
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end
      end

      S_WRITEBACK: begin
        reg_dst    = dec_reg_dst;
        shift      = dec_shift;
        alu_src    = dec_alu_src;
        alu_op     = dec_alu_op;
        mem_to_reg = is_lw;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_nx   = S_FETCH;
      end

      S_HALT: state_nx = S_HALT;

      default: state_nx = S_FETCH;
    endcase
  end

  // State and per-instruction registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_FETCH;
      op_q      <= 4'h0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      wait_cnt  <= wait_nx;
      illegal_q <= illegal_nx;
      bus_err_q <= bus_err_nx;
    end
  end

  // Retired-instruction counter: an instruction retires when the PC is written
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      retired_q <= '0;
    end else if (pc_write) begin
      retired_q <= retired_q + COUNT_W'(1);
    end
  end

  // Strobes are forced low while reset is held so an in-flight access drops at once.
  assign bus.PCWrite      = pc_write   & ~Reset;
  assign bus.IRWrite      = ir_write   & ~Reset;
  assign bus.RegDst       = reg_dst    & ~Reset;
  assign bus.Branch       = branch     & ~Reset;
  assign bus.MemRead      = mem_read   & ~Reset;
  assign bus.MemWrite     = mem_write  & ~Reset;
  assign bus.RegWrite     = reg_write  & ~Reset;
  assign bus.MemToReg     = mem_to_reg & ~Reset;
  assign bus.ALUSrc       = alu_src    & ~Reset;
  assign bus.Shift        = shift      & ~Reset;
  assign bus.ALUOp        = alu_op     & {2{~Reset}};
  assign bus.Halted       = (state == S_HALT);
  assign bus.IllegalOp    = illegal_q;
  assign bus.BusError     = bus_err_q;
  assign bus.RetiredCount = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control_fsm
// Brief   : Self-checking bench for multicycle_control_fsm. An instruction-
//           level reference builds each instruction's expected cycle-by-cycle
//           control schedule from the opcode map and memory wait count.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 15;

  typedef logic [14:0] ctl_t;
  localparam ctl_t PCW  = 15'h4000;
  localparam ctl_t IRW  = 15'h2000;
  localparam ctl_t RDST = 15'h1000;
  localparam ctl_t BR   = 15'h0800;
  localparam ctl_t MRD  = 15'h0400;
  localparam ctl_t MWR  = 15'h0200;
  localparam ctl_t RW   = 15'h0100;
  localparam ctl_t MTR  = 15'h0080;
  localparam ctl_t ASRC = 15'h0040;
  localparam ctl_t SHF  = 15'h0020;
  localparam ctl_t AFN  = 15'h0010;
  localparam ctl_t ASUB = 15'h0008;
  localparam ctl_t AOPC = 15'h0018;
  localparam ctl_t HLT  = 15'h0004;
  localparam ctl_t ILL  = 15'h0002;
  localparam ctl_t BUS  = 15'h0001;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       mem_ready = 1'b0;

  always #5 Clock = ~Clock;

  multicycle_control_fsm_if #(.COUNT_W(16)) bus16 ();
  multicycle_control_fsm_if #(.COUNT_W(4))  bus4 ();

  assign bus16.opcode   = opcode;
  assign bus16.MemReady = mem_ready;
  assign bus4.opcode    = opcode;
  assign bus4.MemReady  = mem_ready;

  multicycle_control_fsm #(.COUNT_W(16), .MEM_TIMEOUT(MEM_TIMEOUT)) dut16 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus16.master)
  );

  multicycle_control_fsm #(.COUNT_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut4 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus4.master)
  );

  int unsigned m_count;
  bit          m_ill, m_bus, m_halt;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic ctl_t get16();
    return {bus16.PCWrite, bus16.IRWrite, bus16.RegDst, bus16.Branch, bus16.MemRead,
            bus16.MemWrite, bus16.RegWrite, bus16.MemToReg, bus16.ALUSrc, bus16.Shift,
            bus16.ALUOp, bus16.Halted, bus16.IllegalOp, bus16.BusError};
  endfunction

  function automatic ctl_t get4();
    return {bus4.PCWrite, bus4.IRWrite, bus4.RegDst, bus4.Branch, bus4.MemRead,
            bus4.MemWrite, bus4.RegWrite, bus4.MemToReg, bus4.ALUSrc, bus4.Shift,
            bus4.ALUOp, bus4.Halted, bus4.IllegalOp, bus4.BusError};
  endfunction

  // Steering implied by the opcode map (Branch is added only for the BEQ execute cycle)
  function automatic ctl_t alu_ctl(input logic [3:0] op);
    case (op)
      4'h0:             return RDST | AFN;
      4'h1:             return RDST | SHF | AFN;
      4'h2, 4'h3, 4'h4: return ASRC | AOPC;
      4'h5, 4'h6:       return ASRC;
      4'h7:             return ASUB;
      default:          return '0;
    endcase
  endfunction

  function automatic ctl_t flags();
    return (m_ill ? ILL : 15'h0) | (m_bus ? BUS : 15'h0) | (m_halt ? HLT : 15'h0);
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare both DUTs at the falling edge, advance.
  task automatic cycle(input logic [3:0] op_in, input logic mr, input ctl_t exp, input string tag);
    opcode    = op_in;
    mem_ready = mr;
    @(negedge Clock);
    check({tag, " ctl16"}, 32'(get16()), 32'(exp));
    check({tag, " ctl4"},  32'(get4()),  32'(exp));
    check({tag, " cnt16"}, 32'(bus16.RetiredCount), 32'(m_count[15:0]));
    check({tag, " cnt4"},  32'(bus4.RetiredCount),  32'(m_count[3:0]));
    if (exp[14]) m_count++;
    cyc++;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("reset ctl16", 32'(get16()), 32'h0);
    check("reset ctl4",  32'(get4()),  32'h0);
    check("reset cnt16", 32'(bus16.RetiredCount), 32'h0);
    check("reset cnt4",  32'(bus4.RetiredCount),  32'h0);
    @(posedge Clock);
    #1;
    Reset   = 1'b0;
    m_count = 0;
    m_ill   = 1'b0;
    m_bus   = 1'b0;
    m_halt  = 1'b0;
  endtask

  // One instruction from FETCH; w = MEM cycles with MemReady low before completion
  // (w > MEM_TIMEOUT means the memory never answers).
  task automatic run_instr(input logic [3:0] op, input int w);
    ctl_t a, strobe;
    bit   done;
    cyc = 0;
    cycle(rnd_op(), 1'($urandom), IRW | flags(), "fetch");
    cycle(op, 1'($urandom), flags(), "decode");
    if (op == 4'hF) begin
      m_halt = 1'b1;
      return;
    end
    if (op[3]) begin
      m_ill  = 1'b1;
      m_halt = 1'b1;
      return;
    end
    a = alu_ctl(op);
    if (op == 4'h7) begin
      cycle(rnd_op(), 1'($urandom), a | BR | PCW | flags(), "exec_beq");
      return;
    end
    cycle(rnd_op(), 1'($urandom), a | flags(), "exec");
    if (op == 4'h5 || op == 4'h6) begin
      strobe = (op == 4'h5) ? MRD : MWR;
      done   = 1'b0;
      for (int k = 0; k <= MEM_TIMEOUT; k++) begin
        if (k < w) begin
          cycle(rnd_op(), 1'b0, a | strobe | flags(), "mem_wait");
        end else begin
          cycle(rnd_op(), 1'b1, a | strobe | ((op == 4'h6) ? PCW : 15'h0) | flags(), "mem_done");
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        m_bus  = 1'b1;
        m_halt = 1'b1;
        return;
      end
      if (op == 4'h6) return;
    end
    cycle(rnd_op(), 1'($urandom), a | RW | PCW | ((op == 4'h5) ? MTR : 15'h0) | flags(), "wb");
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(rnd_op(), 1'($urandom), flags(), "halt");
  endtask

  typedef struct {
    logic [3:0] op;
    int         w;
    int         cycles;
    bit         halt;
    bit         ill;
    bit         bus;
    int         retired;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // op, mem waits, FETCH-to-FETCH (or to HALT) cycles, halted, illegal, bus error, retired
    vecs[0]  = '{4'h0, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'h1, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'h2, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h3, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'h4, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h7, 0,  3,  1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'h5, 3,  8,  1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'h5, 0,  5,  1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h6, 0,  4,  1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h6, 5,  9,  1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'h6, 15, 19, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'h6, 99, 19, 1'b1, 1'b0, 1'b1, 0};
    vecs[12] = '{4'h5, 15, 20, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{4'h5, 99, 19, 1'b1, 1'b0, 1'b1, 0};
    vecs[14] = '{4'hA, 0,  2,  1'b1, 1'b1, 1'b0, 0};
    vecs[15] = '{4'hF, 0,  2,  1'b1, 1'b0, 1'b0, 0};
    vecs[16] = '{4'h8, 0,  2,  1'b1, 1'b1, 1'b0, 0};

    #2;
    do_reset();

    // Directed table: one instruction from reset, then latency and status
    for (int i = 0; i < 17; i++) begin
      do_reset();
      run_instr(vecs[i].op, vecs[i].w);
      check($sformatf("vec%0d cycles", i),  32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("vec%0d halted", i),  32'(bus16.Halted), 32'(vecs[i].halt));
      check($sformatf("vec%0d illegal", i), 32'(bus16.IllegalOp), 32'(vecs[i].ill));
      check($sformatf("vec%0d buserr", i),  32'(bus16.BusError), 32'(vecs[i].bus));
      check($sformatf("vec%0d retired", i), 32'(bus16.RetiredCount), 32'(vecs[i].retired));
      check($sformatf("vec%0d irwrite", i), 32'(bus16.IRWrite), 32'(!vecs[i].halt));
      if (vecs[i].halt) halt_cycles(3);
    end

    // Halt with status persists, then a reset pulse clears it and fetch resumes
    do_reset();
    run_instr(4'hA, 0);
    halt_cycles(4);
    do_reset();
    cycle(rnd_op(), 1'b1, IRW, "post_reset_fetch");

    // Counter wrap: 17 back-to-back ADDI
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(4'h2, 0);
    check("wrap cnt4",  32'(bus4.RetiredCount),  32'd1);
    check("wrap cnt16", 32'(bus16.RetiredCount), 32'd17);

    // Reset in the middle of a store's memory wait
    do_reset();
    run_instr(4'h2, 0);
    cycle(rnd_op(), 1'b0, IRW, "mr_fetch");
    cycle(4'h6, 1'b0, 15'h0, "mr_decode");
    cycle(rnd_op(), 1'b0, ASRC, "mr_exec");
    cycle(rnd_op(), 1'b0, ASRC | MWR, "mr_mem0");
    cycle(rnd_op(), 1'b0, ASRC | MWR, "mr_mem1");
    opcode = rnd_op();
    #3;
    Reset = 1'b1;
    #1;
    check("midmem memwrite", 32'(bus16.MemWrite), 32'h0);
    check("midmem count",    32'(bus16.RetiredCount), 32'h0);
    do_reset();
    cycle(rnd_op(), 1'b0, IRW, "midmem_refetch");

    // Randomized instruction streams against the reference schedule
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int         r, w;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 3)      op = 4'hF;
      else if (r < 7) op = 4'(8 + $urandom_range(0, 6));
      else            op = 4'($urandom_range(0, 7));
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      run_instr(op, w);
      if (m_halt) begin
        halt_cycles(2);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
